input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive cycles a synchronized input must differ from its clean value before the clean value changes (10 ms at 100 MHz); legal range 1 to 2^24.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops per input; legal range 2 to 4.
REQ-003 CLK100MHZ  input  1  single system clock; all state on its rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 SW  input  4  raw slide switches, asynchronous to CLK100MHZ.
REQ-006 BTNC  input  1  raw centre push-button, asynchronous, bouncing.
REQ-007 sw_clean  output  4  debounced switch levels, bit i tracks SW[i].
REQ-008 btnc_level  output  1  debounced BTNC level.
REQ-009 btnc_press  output  1  one-cycle pulse on each debounced BTNC rising edge.
REQ-010 btnc_toggle  output  1  level that inverts once per debounced BTNC press.

Function
REQ-011 Each of the 5 raw inputs SHALL pass through its own SYNC_STAGES-deep flop chain before any other logic sees it.
REQ-012 Each input SHALL have an independent debouncer: a 2-state FSM, STABLE_LO and STABLE_HI, plus a counter of width clog2(DEBOUNCE_CYCLES)+1.
- In STABLE_LO: synced=0 -> counter cleared; synced=1 -> counter+1.
- In STABLE_HI: mirror image.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and the synced input still differs, the FSM SHALL switch state and clear the counter on that edge; clean output equals (state==STABLE_HI).
REQ-014 Any single cycle where synced equals the clean value SHALL clear the counter; partial counts never accumulate across bounces.
REQ-015 Counter SHALL never wrap or exceed DEBOUNCE_CYCLES-1.
REQ-016 Latency: a raw input change held stable SHALL appear on the clean output exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples the new raw value.
REQ-017 DEBOUNCE_CYCLES=1 SHALL make the clean output follow the synced input with one extra cycle of delay.
REQ-018 btnc_press SHALL be high for exactly one cycle, the cycle in which btnc_level first reads 1; no pulse on falling edges.
REQ-019 btnc_toggle SHALL invert on the rising edge that ends a btnc_press cycle, i.e. one cycle after btnc_press asserts.
REQ-020 Each sw_clean bit SHALL be independent of the other bits and of BTNC; simultaneous changes on all inputs SHALL each resolve with the REQ-016 latency.
REQ-021 All outputs SHALL be registered; no combinational path from any raw input to any output.

Reset
REQ-022 RST high SHALL immediately clear all synchronizer flops, counters, sw_clean, btnc_level, btnc_press and btnc_toggle, and force every FSM to STABLE_LO.
REQ-023 Reset mid-debounce SHALL discard the partial count; after release an input held high SHALL need a full SYNC_STAGES+DEBOUNCE_CYCLES before its clean value goes to 1.
REQ-024 A BTNC held high through reset release SHALL produce exactly one btnc_press when btnc_level rises.

Structure
REQ-025 Shared package/include SHALL hold the DEBOUNCE_CYCLES default, the SYNC_STAGES default and the FSM state encodings.
REQ-026 One sub-module, debounce_bit (synchronizer + FSM + counter for one input), SHALL be instantiated 5 times; edge detection and toggle live in input_conditioner.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-027 Clean step: SW[0] 0->1 and held -> sw_clean[0]=1 exactly 6 edges later; other bits stay 0.
REQ-028 Bounce: BTNC toggles 1,0,1,0 on successive 3-cycle intervals, then holds 1 -> btnc_level rises 6 edges after the final rise; exactly one btnc_press; btnc_toggle 0->1 one cycle after that press.
REQ-029 Glitch reject: SW[2] high for 3 cycles then low -> sw_clean[2] never leaves 0.
REQ-030 Two presses: two clean BTNC presses separated by 20 cycles low -> two btnc_press pulses; btnc_toggle returns to 0; release produces no pulse.
REQ-031 Reset mid-count: SW=4'b1111 for 4 cycles, RST pulsed, SW held -> all outputs 0 during reset; sw_clean=4'b1111 exactly 6 edges after the first edge that follows RST deassertion.
REQ-032 Simultaneous: SW and BTNC all rise on the same edge -> sw_clean=4'b1111 and btnc_level=1 on the same cycle; btnc_press asserts in that same cycle.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// ============================================================================
// input_conditioner_pkg : shared defaults and debouncer state encoding
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package input_conditioner_pkg;

  localparam int unsigned C_DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned C_SYNC_STAGES_DEFAULT     = 2;

  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } db_state_e;

endpackage

`default_nettype wire

// File: rtl/input_conditioner_debounce_bit.sv
// ============================================================================
// debounce_bit : synchronizer chain + two-state debounce FSM for one input
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = C_SYNC_STAGES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic clean_d_o
);

  localparam int unsigned    CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   w_synced;
  logic                   w_clean;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
  assign w_synced = sync_q[SYNC_STAGES-1];
  assign w_clean  = (state_q == STABLE_HI);

  // Any agreeing cycle wipes the count, so only an unbroken run can flip state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (w_synced == w_clean) begin
      cnt_d = '0;
    end else if (cnt_q == C_CNT_MAX) begin
      state_d = (state_q == STABLE_HI) ? STABLE_LO : STABLE_HI;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean_d_o = (state_d == STABLE_HI);

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ============================================================================
// input_conditioner : debounced switches and centre button with press/toggle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = C_SYNC_STAGES_DEFAULT
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic [3:0] SW,
  input  logic       BTNC,
  output logic [3:0] sw_clean,
  output logic       btnc_level,
  output logic       btnc_press,
  output logic       btnc_toggle
);

  logic [4:0] w_raw;
  logic [4:0] level_d;
  logic [4:0] level_q;
  logic       press_d, press_q;
  logic       toggle_d, toggle_q;

  assign w_raw = {BTNC, SW};

  generate
    for (genvar i = 0; i < 5; i++) begin : g_db
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_db (
        .clk_i     (CLK100MHZ),
        .rst_i     (RST),
        .raw_i     (w_raw[i]),
        .clean_d_o (level_d[i])
      );
    end
  endgenerate

  // Edge taken from the next-level value so the pulse lines up with the level rise.
  assign press_d  = level_d[4] & ~level_q[4];
  assign toggle_d = toggle_q ^ press_q;

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      level_q  <= '0;
      press_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      press_q  <= press_d;
      toggle_q <= toggle_d;
    end
  end

  assign sw_clean    = level_q[3:0];
  assign btnc_level  = level_q[4];
  assign btnc_press  = press_q;
  assign btnc_toggle = toggle_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ============================================================================
// tb_input_conditioner : directed checks of input_conditioner (DEBOUNCE=4, SYNC=2)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btnc;
  logic [3:0] sw_clean;
  logic       btnc_level;
  logic       btnc_press;
  logic       btnc_toggle;

  int n_checks;
  int n_errors;
  int press_cnt;

  input_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .CLK100MHZ   (clk),
    .RST         (rst),
    .SW          (sw),
    .BTNC        (btnc),
    .sw_clean    (sw_clean),
    .btnc_level  (btnc_level),
    .btnc_press  (btnc_press),
    .btnc_toggle (btnc_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial press_cnt = 0;
  always @(negedge clk) if (btnc_press === 1'b1) press_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each tick returns 1 ns after a rising edge; inputs changed then are
  // first sampled by the following edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"},  {28'd0, sw_clean}, 32'd0);
    check({tag, "_lvl"}, {31'd0, btnc_level}, 32'd0);
    check({tag, "_prs"}, {31'd0, btnc_press}, 32'd0);
    check({tag, "_tgl"}, {31'd0, btnc_toggle}, 32'd0);
  endtask

  initial begin
    int base;
    logic [3:0] seen;
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    sw   = 4'b0000;
    btnc = 1'b0;

    // Reset state
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(3);
    check_all_zero("idle");

    // Clean step on SW[0]: visible on the 6th edge
    sw = 4'b0001;
    tick(5);
    check("step_e5", {28'd0, sw_clean}, 32'h0);
    tick(1);
    check("step_e6", {28'd0, sw_clean}, 32'h1);
    check("step_btn", {31'd0, btnc_level}, 32'd0);
    sw = 4'b0000;
    tick(6);
    check("step_fall", {28'd0, sw_clean}, 32'h0);

    // Glitch of 3 cycles on SW[2] is rejected
    seen = 4'b0000;
    sw = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      seen |= sw_clean;
    end
    sw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen |= sw_clean;
    end
    check("glitch", {28'd0, seen}, 32'h0);

    // Two clean presses with 20 low cycles between
    base = press_cnt;
    btnc = 1'b1;
    tick(10);
    check("p1_lvl", {31'd0, btnc_level}, 32'd1);
    check("p1_tgl", {31'd0, btnc_toggle}, 32'd1);
    btnc = 1'b0;
    tick(20);
    check("p1_rel", {31'd0, btnc_level}, 32'd0);
    check("p1_cnt", press_cnt - base, 32'd1);
    btnc = 1'b1;
    tick(10);
    btnc = 1'b0;
    tick(10);
    check("p2_cnt", press_cnt - base, 32'd2);
    check("p2_tgl", {31'd0, btnc_toggle}, 32'd0);
    check("p2_lvl", {31'd0, btnc_level}, 32'd0);

    // Bouncing button: 1,0,1,0 in 3-cycle slots, then hold 1
    base = press_cnt;
    for (int k = 0; k < 4; k++) begin
      btnc = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick(3);
    end
    check("bnc_quiet", press_cnt - base, 32'd0);
    btnc = 1'b1;
    tick(5);
    check("bnc_e5", {31'd0, btnc_level}, 32'd0);
    tick(1);
    check("bnc_e6_lvl", {31'd0, btnc_level}, 32'd1);
    check("bnc_e6_prs", {31'd0, btnc_press}, 32'd1);
    check("bnc_e6_tgl", {31'd0, btnc_toggle}, 32'd0);
    tick(1);
    check("bnc_e7_prs", {31'd0, btnc_press}, 32'd0);
    check("bnc_e7_tgl", {31'd0, btnc_toggle}, 32'd1);
    tick(10);
    check("bnc_cnt", press_cnt - base, 32'd1);
    btnc = 1'b0;
    tick(10);
    check("bnc_rel", press_cnt - base, 32'd1);

    // Reset in the middle of a count
    sw = 4'b1111;
    tick(4);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    tick(2);
    check_all_zero("rst_hold");
    rst = 1'b0;
    tick(5);
    check("rst_e5", {28'd0, sw_clean}, 32'h0);
    tick(1);
    check("rst_e6", {28'd0, sw_clean}, 32'hF);

    // All inputs rising on the same edge
    sw = 4'b0000;
    tick(10);
    check("sim_pre", {28'd0, sw_clean}, 32'h0);
    base = press_cnt;
    sw   = 4'b1111;
    btnc = 1'b1;
    tick(5);
    check("sim_e5_sw",  {28'd0, sw_clean}, 32'h0);
    check("sim_e5_lvl", {31'd0, btnc_level}, 32'd0);
    tick(1);
    check("sim_e6_sw",  {28'd0, sw_clean}, 32'hF);
    check("sim_e6_lvl", {31'd0, btnc_level}, 32'd1);
    check("sim_e6_prs", {31'd0, btnc_press}, 32'd1);
    tick(1);
    check("sim_e7_tgl", {31'd0, btnc_toggle}, 32'd1);

    // Button held through reset release gives exactly one press
    rst = 1'b1;
    tick(2);
    check_all_zero("hold_rst");
    base = press_cnt;
    rst  = 1'b0;
    tick(5);
    check("hold_e5", {31'd0, btnc_level}, 32'd0);
    tick(1);
    check("hold_e6_lvl", {31'd0, btnc_level}, 32'd1);
    check("hold_e6_prs", {31'd0, btnc_press}, 32'd1);
    tick(10);
    check("hold_cnt", press_cnt - base, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
